// File: rtl/ib_vnu_ram_loader.sv
// Streams one frame half of IB-LUT page words into the VNU function-RAM write port.
// Optional XOR checksum of written words: define IB_LOAD_CHECKSUM_EN.
module ib_vnu_ram_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int BANK_NUM        = 2,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int PAGE_NUM        = 2**(ENTRY_ADDR-1)
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              load_start,
  input  logic                              load_frame,
  input  logic                              read_addr_offset,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
  input  logic                              src_valid,
  output logic                              src_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_0,
  output logic                              ib_ram_we,
  output logic                              load_busy,
  output logic                              load_done,
  output logic                              load_err
`ifdef IB_LOAD_CHECKSUM_EN
  ,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] load_checksum
`endif
);

  localparam int PW = ENTRY_ADDR - 1;
  localparam int DW = LUT_PORT_SIZE * BANK_NUM;
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGE_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] page_cnt;
  logic          frame;
  logic          start_ok;
  logic          start_bad;
  logic          beat;
  logic          last_beat;

  // Width-only parameters kept for interface compatibility.
  logic unused_cfg;
  assign unused_cfg = (QUAN_SIZE > 0) ^ (MULTI_FRAME_NUM == 2);

  // Conflict check only happens at start; the read side may move during a load.
  always_comb begin
    start_ok  = (state == IDLE) && load_start && (load_frame != read_addr_offset);
    start_bad = (state == IDLE) && load_start && (load_frame == read_addr_offset);
    beat      = src_valid && src_ready;
    last_beat = beat && (page_cnt == LAST_PAGE);
  end

  always_ff @(posedge write_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)  state_nxt = LOAD;
      LOAD:    if (last_beat) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_ready = (state == LOAD);
    load_busy = (state != IDLE);
    load_done = (state == FLUSH);
  end

  // page_cnt parks on the last page during FLUSH and only wraps on exit.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      page_cnt         <= '0;
      frame            <= 1'b0;
      page_addr_ram    <= '0;
      ram_write_data_0 <= '0;
      ib_ram_we        <= 1'b0;
      load_err         <= 1'b0;
    end else begin
      ib_ram_we <= beat;
      load_err  <= start_bad;
      if (start_ok) begin
        frame    <= load_frame;
        page_cnt <= '0;
      end
      if (beat) begin
        page_addr_ram    <= {frame, page_cnt};
        ram_write_data_0 <= src_data;
        if (!last_beat) page_cnt <= page_cnt + PW'(1);
      end
      if (state == FLUSH) page_cnt <= '0;
    end
  end

`ifdef IB_LOAD_CHECKSUM_EN
  logic [DW-1:0] csum_acc;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      csum_acc      <= '0;
      load_checksum <= '0;
    end else begin
      if (start_ok) begin
        csum_acc      <= '0;
        load_checksum <= '0;
      end
      if (beat) csum_acc <= csum_acc ^ src_data;
      if (last_beat) load_checksum <= csum_acc ^ src_data;
    end
  end
`else
  logic [DW-1:0] unused_dw;
  assign unused_dw = '0;
`endif

endmodule

// File: tb/tb_ib_vnu_ram_loader.sv
// Directed bench for ib_vnu_ram_loader with a write-port scoreboard.
module tb_ib_vnu_ram_loader;

  logic       write_clk;
  logic       rst;
  logic       load_start;
  logic       load_frame;
  logic       read_addr_offset;
  logic [5:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [4:0] page_addr_ram;
  logic [5:0] ram_write_data_0;
  logic       ib_ram_we;
  logic       load_busy;
  logic       load_done;
  logic       load_err;
`ifdef IB_LOAD_CHECKSUM_EN
  logic [5:0] load_checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_e;

  ib_vnu_ram_loader #(
    .QUAN_SIZE(3), .ENTRY_ADDR(5), .MULTI_FRAME_NUM(2),
    .BANK_NUM(2), .LUT_PORT_SIZE(3), .PAGE_NUM(16)
  ) dut (
    .write_clk(write_clk), .rst(rst), .load_start(load_start),
    .load_frame(load_frame), .read_addr_offset(read_addr_offset),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .page_addr_ram(page_addr_ram), .ram_write_data_0(ram_write_data_0),
    .ib_ram_we(ib_ram_we), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err)
`ifdef IB_LOAD_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge write_clk);
    #1;
  endtask

  // Every write on the RAM port must match the oldest expected beat.
  always @(negedge write_clk) begin
    if (ib_ram_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(ib_ram_we), 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 32'(page_addr_ram), 32'(exp_e[10:6]));
        chk("wr_data", 32'(ram_write_data_0), 32'(exp_e[5:0]));
      end
    end
  end

  // mode: 0 data=page, 1 random, 2 alternating 3F/00, 3 single 2A at page 9
  task automatic run_load(input logic frame, input logic offs, input int mode, input int restart_at);
    logic [5:0] d;
    logic [5:0] csum;
    csum = '0;
    load_start = 1'b1; load_frame = frame; read_addr_offset = offs;
    cyc();
    load_start = 1'b0;
    chk("busy_after_start", 32'(load_busy), 32'd1);
    chk("ready_after_start", 32'(src_ready), 32'd1);
    chk("err_after_start", 32'(load_err), 32'd0);
    chk("we_after_start", 32'(ib_ram_we), 32'd0);
    for (int p = 0; p < 16; p++) begin
      case (mode)
        0:       d = 6'(p);
        1:       d = 6'($urandom);
        2:       d = (p % 2 == 0) ? 6'h3F : 6'h00;
        default: d = (p == 9) ? 6'h2A : 6'h00;
      endcase
      src_valid = 1'b1; src_data = d; csum = csum ^ d;
      exp_q.push_back({frame, 4'(p), d});
      if (p == restart_at) begin
        load_start = 1'b1; load_frame = ~frame; read_addr_offset = frame;
      end
      cyc();
      load_start = 1'b0;
      chk("beat_we", 32'(ib_ram_we), 32'd1);
      chk("beat_err", 32'(load_err), 32'd0);
      chk("beat_done", 32'(load_done), 32'(p == 15));
      chk("beat_busy", 32'(load_busy), 32'd1);
    end
    src_valid = 1'b0;
    chk("last_addr", 32'(page_addr_ram), 32'({frame, 4'hF}));
    chk("flush_ready", 32'(src_ready), 32'd0);
`ifdef IB_LOAD_CHECKSUM_EN
    chk("checksum", 32'(load_checksum), 32'(csum));
`endif
    cyc();
    chk("end_busy", 32'(load_busy), 32'd0);
    chk("end_done", 32'(load_done), 32'd0);
    chk("end_we", 32'(ib_ram_we), 32'd0);
`ifdef IB_LOAD_CHECKSUM_EN
    chk("checksum_hold", 32'(load_checksum), 32'(csum));
`endif
  endtask

  initial begin
    logic v;
    logic [5:0] d;
    rst = 1'b1; load_start = 1'b0; load_frame = 1'b0; read_addr_offset = 1'b0;
    src_data = '0; src_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_addr", 32'(page_addr_ram), 32'd0);
    chk("rst_data", 32'(ram_write_data_0), 32'd0);
    chk("rst_we", 32'(ib_ram_we), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
`ifdef IB_LOAD_CHECKSUM_EN
    chk("rst_checksum", 32'(load_checksum), 32'd0);
`endif
    rst = 1'b0;
    cyc();

    // back-to-back, frame 1, data = page index
    run_load(1'b1, 1'b0, 0, -1);

    // valid toggling every cycle
    load_start = 1'b1; load_frame = 1'b0; read_addr_offset = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      v = (i % 2 == 0);
      d = 6'($urandom);
      src_valid = v; src_data = d;
      if (v) exp_q.push_back({1'b0, 4'(i / 2), d});
      cyc();
      chk("toggle_we", 32'(ib_ram_we), 32'(v));
      chk("toggle_done", 32'(load_done), 32'(i == 30));
    end
    src_valid = 1'b0;
    cyc();
    chk("toggle_end_busy", 32'(load_busy), 32'd0);

    // frame conflict: rejected, no writes
    src_valid = 1'b1; src_data = 6'h15;
    load_start = 1'b1; load_frame = 1'b0; read_addr_offset = 1'b0;
    cyc();
    load_start = 1'b0;
    chk("conflict_err", 32'(load_err), 32'd1);
    chk("conflict_busy", 32'(load_busy), 32'd0);
    chk("conflict_ready", 32'(src_ready), 32'd0);
    chk("conflict_we", 32'(ib_ram_we), 32'd0);
    cyc();
    chk("conflict_err_pulse", 32'(load_err), 32'd0);
    chk("conflict_ready2", 32'(src_ready), 32'd0);
    src_valid = 1'b0;
    cyc();

    // reset at beat 7, then a fresh load from page 0
    load_start = 1'b1; load_frame = 1'b1; read_addr_offset = 1'b0;
    cyc();
    load_start = 1'b0;
    for (int p = 0; p < 7; p++) begin
      src_valid = 1'b1; src_data = 6'(p + 8);
      exp_q.push_back({1'b1, 4'(p), 6'(p + 8)});
      cyc();
      chk("pre_rst_we", 32'(ib_ram_we), 32'd1);
    end
    rst = 1'b1; src_data = 6'h3F;
    cyc();
    chk("midrst_we", 32'(ib_ram_we), 32'd0);
    chk("midrst_busy", 32'(load_busy), 32'd0);
    chk("midrst_ready", 32'(src_ready), 32'd0);
    rst = 1'b0; src_valid = 1'b0;
    cyc();
    chk("post_rst_we", 32'(ib_ram_we), 32'd0);
    run_load(1'b1, 1'b0, 1, -1);

    // start pulse during an active load is ignored; offset change does not abort
    run_load(1'b0, 1'b1, 1, 5);

    // checksum patterns (also plain loads when the feature is absent)
    run_load(1'b1, 1'b0, 2, -1);
    run_load(1'b0, 1'b1, 3, -1);

    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ib_vnu_ram_loader.md
# ib_vnu_ram_loader

Iteration-update loader that sits directly upstream of the 3-input VNU function-RAM stage and drives its write port (`page_addr_ram`, `ram_write_data_0`, `ib_ram_we`). It accepts a stream of per-iteration IB-LUT page words from the decoder's LUT source. It sweeps every page of one multi-frame half of the IB-VNU RAM and writes each word with the frame-offset bit in the address MSB. It refuses to overwrite the frame half currently selected for reading.

## Interface
Parameters:
- `QUAN_SIZE`, 3, message quantisation width; informational, not used in datapath widths.
- `ENTRY_ADDR`, 5, full page address width, including the 1-bit frame offset in the MSB.
- `MULTI_FRAME_NUM`, 2, number of frame halves; fixed at 2.
- `BANK_NUM`, 2, banks per page word.
- `LUT_PORT_SIZE`, 3, bits per bank entry.
- `PAGE_NUM`, 2**(ENTRY_ADDR-1) = 16, pages per frame half; also the beat count per load.

Ports:
- `write_clk`, in, 1, the only clock; all logic is on its rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `load_start`, in, 1, single-cycle request to begin one load.
- `load_frame`, in, 1, target frame half; sampled with `load_start`.
- `read_addr_offset`, in, 1, frame half the read side is currently using.
- `src_data`, in, LUT_PORT_SIZE*BANK_NUM, page word; bank0 is in the upper LUT_PORT_SIZE bits.
- `src_valid`, in, 1, `src_data` is valid.
- `src_ready`, out, 1, loader accepts a beat.
- `page_addr_ram`, out, ENTRY_ADDR, write address `{frame, page}`.
- `ram_write_data_0`, out, LUT_PORT_SIZE*BANK_NUM, write data.
- `ib_ram_we`, out, 1, write enable.
- `load_busy`, out, 1, a load is in progress.
- `load_done`, out, 1, one-cycle pulse, coincident with the final write.
- `load_err`, out, 1, one-cycle pulse when a start is rejected for frame conflict.
- `load_checksum`, out, LUT_PORT_SIZE*BANK_NUM, present only under `IB_LOAD_CHECKSUM_EN`.

## Operation
- States:
  - `IDLE`: no load in progress.
  - `LOAD`: accepting beats.
  - `FLUSH`: final write cycle.
- `IDLE` transitions:
  - `load_start`=1 and `load_frame`≠`read_addr_offset`: latch the frame, clear the page counter, go to `LOAD`.
  - `load_start`=1 and `load_frame`==`read_addr_offset`: pulse `load_err` next cycle and stay in `IDLE`.
- `LOAD` behaviour:
  - `src_ready`=1, decoded from the registered state.
  - A beat is accepted when `src_valid & src_ready`.
  - On each accepted beat, register `page_addr_ram`={frame, page_cnt}, `ram_write_data_0`=`src_data`, `ib_ram_we`=1, then increment `page_cnt`.
  - The beat accepted with `page_cnt`==PAGE_NUM-1 moves the FSM to `FLUSH`.
- `FLUSH`: `src_ready`=0; the final write is on the outputs and `load_done`=1; return to `IDLE` next cycle.
- `page_cnt` is (ENTRY_ADDR-1) bits wide. It wraps from PAGE_NUM-1 to 0 only at `FLUSH` exit; it is cleared on accepted start.
- `ib_ram_we`=0 in every cycle without a newly accepted beat. Address and data hold their last values when idle.
- `load_start` while `load_busy`=1 is ignored: no error pulse, no restart.
- Source stalls (`src_valid`=0 in `LOAD`) are unbounded; the loader waits with `ib_ram_we`=0.
- A change of `read_addr_offset` during a load does not abort it; the conflict check happens only at start.

## Timing
- Reset value of every output: 0, including `load_checksum`.
- `rst` mid-load returns the FSM to `IDLE` on the next edge and drops `ib_ram_we`. Partial RAM contents are left as written.
- Beat accepted at cycle n → `ib_ram_we`=1 with its address and data at n+1.
- Last beat accepted at n → `load_done`=1 and final write at n+1; `load_busy` falls at n+2.
- `load_busy` is 1 from the cycle after an accepted start through the `FLUSH` cycle inclusive.
- A new start is accepted no earlier than the cycle `load_busy`=0.
- Minimum load duration: PAGE_NUM+1 cycles after start (17 with defaults).
- `load_err` pulse occurs at start+1.

## Configuration
- `IB_LOAD_CHECKSUM_EN` defined:
  - A register XOR-accumulates every written word. It is cleared on accepted start.
  - `load_checksum` updates in the same cycle as `load_done` and holds until the next accepted start or reset.
- `IB_LOAD_CHECKSUM_EN` undefined: the accumulator and the `load_checksum` port are absent. All other behaviour is identical.

## Test plan
- Back-to-back stream, `load_frame`=1, `read_addr_offset`=0, data = page index:
  - 16 writes to addresses 0x10..0x1F with data 0..15 on consecutive cycles.
  - `load_done` with address 0x1F; `load_busy` low 18 cycles after start.
- `src_valid` toggling 1/0 every cycle: 16 writes spread over 32 cycles, no gaps or duplicate addresses, `ib_ram_we` never high on a stall cycle.
- `load_frame`=0, `read_addr_offset`=0: `load_err`=1 one cycle later, `src_ready` stays 0, no writes.
- Reset at beat 7, then a new start: no `ib_ram_we` after reset; the new load starts again at page 0.
- `load_start` pulsed at beat 5 of an active load: ignored, address sequence continues from 6, no `load_err`.
- With `IB_LOAD_CHECKSUM_EN`, data 0x3F,0x00 alternating over 16 beats: `load_checksum`=0x00; a single 0x2A beat among zeros gives 0x2A.
